// File: rtl/fp_minmax_reduce_if.sv
// Stream and result bundle for fp_minmax_reduce.
//
// Signals:
//   start      - one-cycle reduction request (honoured only while idle)
//   max_n_min  - 1 = running maximum, 0 = running minimum
//   len        - number of elements in the vector
//   in_valid   - element valid
//   in_data    - floating-point element
//   in_ready   - reducer accepts an element this cycle
//   busy       - reduction in progress
//   done       - one-cycle pulse, result fields valid
//   res        - reduced value
//   res_idx    - 0-based index of the selected element
//   all_nan    - every element was NaN, or len was 0
//
// master: the requester/producer side. slave: the reducer.
interface fp_minmax_reduce_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
);
  logic              start;
  logic              max_n_min;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] res;
  logic [LEN_W-1:0]  res_idx;
  logic              all_nan;

  modport master (
    output start, max_n_min, len, in_valid, in_data,
    input  in_ready, busy, done, res, res_idx, all_nan
  );

  modport slave (
    input  start, max_n_min, len, in_valid, in_data,
    output in_ready, busy, done, res, res_idx, all_nan
  );
endinterface

// File: rtl/fp_minmax_reduce.sv
// Streaming vector min/max reducer for IEEE-style sign/exponent/mantissa words.
//
// Accepts LEN elements one per cycle over a valid/ready stream and keeps a running
// maximum or minimum together with the index of the winning element. NaN elements
// are skipped; if nothing but NaNs (or no elements at all) arrive, the result is the
// canonical quiet NaN with all_nan set.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-low reset
//   bus  - fp_minmax_reduce_if.slave: start/mode/len request, element stream,
//          busy/done status and the registered result (res, res_idx, all_nan)
module fp_minmax_reduce #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned LEN_W  = 16
) (
  input logic               clk,
  input logic               rst,
  fp_minmax_reduce_if.slave bus
);

  localparam int unsigned MAN_W = DATA_W - 1 - EXP_W;
  localparam logic [DATA_W-1:0] CanonNan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StFinish} state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              acc_valid_q, acc_valid_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [LEN_W-1:0]  res_idx_q, res_idx_d;
  logic              all_nan_q, all_nan_d;

  // Exponent all ones with a nonzero mantissa.
  function automatic logic is_nan(input logic [DATA_W-1:0] x);
    return (&x[DATA_W-2 -: EXP_W]) && (|x[MAN_W-1:0]);
  endfunction

  // a strictly greater than b under sign-magnitude ordering (+0 > -0, infinities
  // are just the largest magnitudes).
  function automatic logic fp_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-2:0] mag_a;
    logic [DATA_W-2:0] mag_b;
    mag_a = a[DATA_W-2:0];
    mag_b = b[DATA_W-2:0];
    if (a[DATA_W-1] != b[DATA_W-1]) begin
      return !a[DATA_W-1];
    end else if (!a[DATA_W-1]) begin
      return mag_a > mag_b;
    end else begin
      return mag_a < mag_b;
    end
  endfunction

  logic accept;
  logic elem_nan;
  logic elem_better;
  logic last_elem;

  assign accept      = bus.in_valid && (state_q == StAccum);
  assign elem_nan    = is_nan(bus.in_data);
  // Strict comparison so that ties keep the earlier index.
  assign elem_better = mode_q ? fp_gt(bus.in_data, acc_q) : fp_gt(acc_q, bus.in_data);
  assign last_elem   = (count_q == (len_q - LEN_W'(1)));

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    count_d     = count_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    acc_valid_d = acc_valid_q;
    res_d       = res_q;
    res_idx_d   = res_idx_q;
    all_nan_d   = all_nan_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d      = bus.max_n_min;
          len_d       = bus.len;
          count_d     = '0;
          acc_d       = '0;
          idx_d       = '0;
          acc_valid_d = 1'b0;
          if (bus.len != '0) begin
            state_d = StAccum;
          end else begin
            // Empty vector: straight to the NaN result.
            state_d   = StFinish;
            res_d     = CanonNan;
            res_idx_d = '0;
            all_nan_d = 1'b1;
          end
        end
      end

      StAccum: begin
        if (accept) begin
          if (!elem_nan && (!acc_valid_q || elem_better)) begin
            acc_d       = bus.in_data;
            idx_d       = count_q;
            acc_valid_d = 1'b1;
          end
          count_d = count_q + LEN_W'(1);
          if (last_elem) begin
            // Result registers load on entry to FINISH, including the last element.
            state_d = StFinish;
            if (acc_valid_d) begin
              res_d     = acc_d;
              res_idx_d = idx_d;
              all_nan_d = 1'b0;
            end else begin
              res_d     = CanonNan;
              res_idx_d = '0;
              all_nan_d = 1'b1;
            end
          end
        end
      end

      StFinish: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      len_q       <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      acc_valid_q <= 1'b0;
      res_q       <= '0;
      res_idx_q   <= '0;
      all_nan_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      acc_valid_q <= acc_valid_d;
      res_q       <= res_d;
      res_idx_q   <= res_idx_d;
      all_nan_q   <= all_nan_d;
    end
  end

  assign bus.in_ready = (state_q == StAccum);
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StFinish);
  assign bus.res      = res_q;
  assign bus.res_idx  = res_idx_q;
  assign bus.all_nan  = all_nan_q;

endmodule

// File: tb/tb_fp_minmax_reduce.sv
module tb_fp_minmax_reduce;

  logic clk;
  logic rst;

  fp_minmax_reduce_if #(.DATA_W(32), .LEN_W(16)) bus ();

  fp_minmax_reduce #(
    .DATA_W(32),
    .EXP_W (8),
    .LEN_W (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  typedef struct packed {
    logic             mx;
    logic [15:0]      n;
    logic [3:0][31:0] d;
    logic [31:0]      er;
    logic [15:0]      ei;
    logic             ea;
    logic [7:0]       gap;
    int               lat;  // expected start-to-done cycles, -1 when stalls are used
  } vec_t;

  vec_t tv[16];
  int   nt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic mx, input int n, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] d2, input logic [31:0] d3, input logic [31:0] er,
                     input int ei, input logic ea, input int gap, input int lat);
    tv[nt].mx  = mx;
    tv[nt].n   = 16'(n);
    tv[nt].d[0] = d0;
    tv[nt].d[1] = d1;
    tv[nt].d[2] = d2;
    tv[nt].d[3] = d3;
    tv[nt].er  = er;
    tv[nt].ei  = 16'(ei);
    tv[nt].ea  = ea;
    tv[nt].gap = 8'(gap);
    tv[nt].lat = lat;
    nt++;
  endtask

  // Reference model: map each word onto an unsigned key whose integer order is the
  // floating-point order (-0 below +0), then pick the first strict extreme.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic bit fnan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  task automatic model(input bit mx, input logic [31:0] d[$], output logic [31:0] r,
                       output logic [15:0] ri, output logic an);
    bit found;
    found = 0;
    r = 32'h7FC0_0000;
    ri = '0;
    an = 1'b1;
    foreach (d[i]) begin
      if (!fnan(d[i])) begin
        if (!found || (mx ? (fkey(d[i]) > fkey(r)) : (fkey(d[i]) < fkey(r)))) begin
          r = d[i];
          ri = 16'(i);
          an = 1'b0;
          found = 1;
        end
      end
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] prev);
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7F80_0000;
      3: return 32'hFF80_0000;
      4: return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
      5, 6: return prev;
      default: return $urandom;
    endcase
  endfunction

  // Issue one reduction and stream the elements, optionally with random gaps and an
  // extra start pulse (different mode/len) while accumulating.
  task automatic run(input bit mx, input int n, input logic [31:0] d[$], input int gap_pct,
                     input bit poke, output logic [31:0] r, output logic [15:0] ri,
                     output logic an, output int lat, output int dones, output int ready_bad,
                     output int ready_cnt);
    int k;
    int budget;
    bit got;
    k = 0;
    got = 0;
    budget = 0;
    dones = 0;
    ready_bad = 0;
    ready_cnt = 0;
    r = '0;
    ri = '0;
    an = 1'b0;
    bus.start = 1'b1;
    bus.max_n_min = mx;
    bus.len = 16'(n);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 1;
    while (!got && budget < 400) begin
      if (bus.done) begin
        got = 1;
        dones++;
        r = bus.res;
        ri = bus.res_idx;
        an = bus.all_nan;
        bus.in_valid = 1'b0;
      end else begin
        if (bus.in_ready) ready_cnt++;
        if (bus.busy && !bus.in_ready) ready_bad++;
        bus.start = 1'b0;
        if (poke && k == 1) begin
          bus.start = 1'b1;
          bus.max_n_min = !mx;
          bus.len = 16'd1;
        end
        if (bus.in_ready && k < n && ($urandom_range(0, 99) >= 32'(gap_pct))) begin
          bus.in_valid = 1'b1;
          bus.in_data = d[k];
          k++;
        end else begin
          bus.in_valid = 1'b0;
          bus.in_data = $urandom;
        end
        @(posedge clk);
        #1;
        lat++;
        budget++;
      end
    end
    if (!got) check("timeout_waiting_done", 64'(got), 64'(1));
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
  endtask

  logic [31:0] q[$];
  logic [31:0] r, er;
  logic [15:0] ri, ei;
  logic        an, ea;
  int          lat, dones, rbad, rcnt;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nt = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.max_n_min = 1'b0;
    bus.len = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_in_ready", 64'(bus.in_ready), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_res", 64'(bus.res), 64'(0));
    check("reset_res_idx", 64'(bus.res_idx), 64'(0));
    check("reset_all_nan", 64'(bus.all_nan), 64'(0));
    rst = 1'b1;

    // mx, n, d0..d3, res, idx, all_nan, gap%, latency
    add(1, 4, 32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 32'h4000_0000,
        32'h4040_0000, 1, 0, 0, 5);
    add(0, 3, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0,
        32'h8000_0000, 0, 0, 40, -1);
    add(1, 3, 32'h7FC0_0001, 32'hFF80_0000, 32'h7FA0_0000, 32'h0,
        32'hFF80_0000, 1, 0, 0, 4);
    add(1, 2, 32'h7FC0_0000, 32'hFFFF_FFFF, 32'h0, 32'h0,
        32'h7FC0_0000, 0, 1, 0, 3);
    add(1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7FC0_0000, 0, 1, 0, 1);
    add(0, 1, 32'h7F80_0001, 32'h0, 32'h0, 32'h0, 32'h7FC0_0000, 0, 1, 0, 2);
    add(0, 1, 32'hC120_0000, 32'h0, 32'h0, 32'h0, 32'hC120_0000, 0, 0, 30, -1);
    add(1, 2, 32'h4000_0000, 32'h4000_0000, 32'h0, 32'h0, 32'h4000_0000, 0, 0, 0, 3);
    add(0, 4, 32'h3F80_0000, 32'hBF80_0000, 32'hFF80_0000, 32'h7F80_0000,
        32'hFF80_0000, 2, 0, 20, -1);
    add(1, 4, 32'h3F80_0000, 32'hBF80_0000, 32'hFF80_0000, 32'h7F80_0000,
        32'h7F80_0000, 3, 0, 0, 5);
    add(0, 3, 32'hBF80_0000, 32'hC000_0000, 32'hBF80_0000, 32'h0,
        32'hC000_0000, 1, 0, 0, 4);
    add(1, 2, 32'h0000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h0000_0000, 0, 0, 0, 3);

    for (int t = 0; t < nt; t++) begin
      q.delete();
      for (int j = 0; j < int'(tv[t].n); j++) q.push_back(tv[t].d[j]);
      run(tv[t].mx, int'(tv[t].n), q, int'(tv[t].gap), 1'b0, r, ri, an, lat, dones, rbad,
          rcnt);
      check($sformatf("vec%0d_res", t), 64'(r), 64'(tv[t].er));
      check($sformatf("vec%0d_res_idx", t), 64'(ri), 64'(tv[t].ei));
      check($sformatf("vec%0d_all_nan", t), 64'(an), 64'(tv[t].ea));
      check($sformatf("vec%0d_done_pulses", t), 64'(dones), 64'(1));
      check($sformatf("vec%0d_ready_drop", t), 64'(rbad), 64'(0));
      if (tv[t].lat >= 0) check($sformatf("vec%0d_latency", t), 64'(lat), 64'(tv[t].lat));
      if (tv[t].n == 0) check($sformatf("vec%0d_ready_len0", t), 64'(rcnt), 64'(0));
    end

    // Start pulse during ACCUM (opposite mode, len=1) must be ignored.
    q = '{32'h3F80_0000, 32'h4100_0000, 32'hC100_0000};
    run(1'b1, 3, q, 0, 1'b1, r, ri, an, lat, dones, rbad, rcnt);
    check("poke_res", 64'(r), 64'(32'h4100_0000));
    check("poke_res_idx", 64'(ri), 64'(1));
    check("poke_latency", 64'(lat), 64'(4));
    check("poke_done_pulses", 64'(dones), 64'(1));

    // Randomised runs against the reference model.
    for (int t = 0; t < 40; t++) begin
      int n;
      bit mx;
      logic [31:0] prev;
      n = int'($urandom_range(0, 8));
      mx = 1'($urandom_range(0, 1));
      prev = $urandom;
      q.delete();
      for (int j = 0; j < n; j++) begin
        prev = pick(prev);
        q.push_back(prev);
      end
      model(mx, q, er, ei, ea);
      run(mx, n, q, int'($urandom_range(0, 50)), 1'($urandom_range(0, 3) == 0), r, ri, an, lat,
          dones, rbad, rcnt);
      check($sformatf("rnd%0d_res", t), 64'(r), 64'(er));
      check($sformatf("rnd%0d_res_idx", t), 64'(ri), 64'(ei));
      check($sformatf("rnd%0d_all_nan", t), 64'(an), 64'(ea));
      check($sformatf("rnd%0d_done_pulses", t), 64'(dones), 64'(1));
    end

    // Reset in the middle of a 5-element run after 2 accepted elements.
    q = '{32'hC120_0000};
    run(1'b0, 1, q, 0, 1'b0, r, ri, an, lat, dones, rbad, rcnt);
    check("prerst_res", 64'(r), 64'(32'hC120_0000));
    bus.start = 1'b1;
    bus.max_n_min = 1'b1;
    bus.len = 16'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h4000_0000;
    @(posedge clk);
    #1;
    bus.in_data = 32'h4080_0000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
    check("midrst_done", 64'(bus.done), 64'(0));
    check("midrst_res", 64'(bus.res), 64'(0));
    check("midrst_res_idx", 64'(bus.res_idx), 64'(0));
    rst = 1'b1;
    dones = 0;
    rcnt = 0;
    repeat (6) begin
      bus.in_valid = 1'b1;
      bus.in_data = 32'h4000_0000;
      @(posedge clk);
      #1;
      if (bus.done) dones++;
      if (bus.in_ready) rcnt++;
    end
    bus.in_valid = 1'b0;
    check("postrst_no_done", 64'(dones), 64'(0));
    check("postrst_no_ready", 64'(rcnt), 64'(0));
    q = '{32'h4120_0000};
    run(1'b1, 1, q, 0, 1'b0, r, ri, an, lat, dones, rbad, rcnt);
    check("afterrst_res", 64'(r), 64'(32'h4120_0000));
    check("afterrst_res_idx", 64'(ri), 64'(0));
    check("afterrst_all_nan", 64'(an), 64'(0));

    // Back-to-back: start held high across two len=2 max runs.
    begin
      logic [31:0] d4[4];
      logic [31:0] rs[2];
      logic [15:0] ix[2];
      int dc[2];
      int k, seen, cyc, extra;
      logic [31:0] prev;
      prev = $urandom;
      for (int j = 0; j < 4; j++) begin
        prev = pick(prev);
        d4[j] = prev;
      end
      rs[0] = '0;
      rs[1] = '0;
      ix[0] = '0;
      ix[1] = '0;
      dc[0] = 0;
      dc[1] = 0;
      k = 0;
      seen = 0;
      cyc = 0;
      bus.start = 1'b1;
      bus.max_n_min = 1'b1;
      bus.len = 16'd2;
      @(posedge clk);
      #1;
      while (seen < 2 && cyc < 40) begin
        if (bus.done) begin
          rs[seen] = bus.res;
          ix[seen] = bus.res_idx;
          dc[seen] = cyc;
          seen++;
          if (seen == 2) bus.start = 1'b0;
        end
        if (bus.in_ready && k < 4) begin
          bus.in_valid = 1'b1;
          bus.in_data = d4[k];
          k++;
        end else begin
          bus.in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      check("b2b_done_count", 64'(seen), 64'(2));
      check("b2b_done_spacing", 64'(dc[1] - dc[0]), 64'(4));
      q = '{d4[0], d4[1]};
      model(1'b1, q, er, ei, ea);
      check("b2b_run0_res", 64'(rs[0]), 64'(er));
      check("b2b_run0_idx", 64'(ix[0]), 64'(ei));
      q = '{d4[2], d4[3]};
      model(1'b1, q, er, ei, ea);
      check("b2b_run1_res", 64'(rs[1]), 64'(er));
      check("b2b_run1_idx", 64'(ix[1]), 64'(ei));
      extra = 0;
      repeat (4) begin
        @(posedge clk);
        #1;
        if (bus.done) extra++;
      end
      check("b2b_no_extra_done", 64'(extra), 64'(0));
      check("b2b_idle_after", 64'(bus.busy), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_minmax_reduce.md
Name: fp_minmax_reduce

Overview:
Streaming front-end for the FPU min/max datapath. It accepts a vector of LEN floating-point elements over a valid/ready stream, one element per cycle, and keeps a running maximum or minimum. It returns the final value, the index of the selected element and an all-NaN flag. It lets software obtain vector min/max/argmin/argmax without issuing LEN-1 separate scalar min/max operations.

Parameters:
DATA_W, 32, floating-point word width (sign, exponent, mantissa)
EXP_W, 8, exponent width
LEN_W, 16, width of the vector length and index

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
start  input  1  one-cycle request to begin a reduction; sampled only in IDLE
max_n_min  input  1  1 = maximum, 0 = minimum; latched on accepted start
len  input  LEN_W  number of elements; latched on accepted start
in_valid  input  1  element valid
in_data  input  DATA_W  element
in_ready  output  1  block accepts an element this cycle
busy  output  1  reduction in progress (state != IDLE)
done  output  1  one-cycle pulse; result outputs valid this cycle
res  output  DATA_W  reduced value
res_idx  output  LEN_W  index (0-based) of the element selected as res
all_nan  output  1  every element was NaN, or len was 0

Behaviour:
- One clock; rst is synchronous and active-low. On rst=0 at a clk edge: state=IDLE, in_ready=0, busy=0, done=0, res=0, res_idx=0, all_nan=0, internal counters and accumulator are cleared. Reset mid-reduction aborts it: no done pulse, and partial results are discarded.
- NaN: exponent all ones and mantissa nonzero. Canonical NaN = {1'b0, EXP_W ones, 1'b1, zeros}, which is 0x7FC00000 for 32 bits.
- Ordering uses sign-magnitude:
  - Opposite signs: the positive operand is bigger, so +0 > -0.
  - Both positive: the larger magnitude is bigger.
  - Both negative: the smaller magnitude is bigger.
  - Infinities compare as normal magnitudes.
- States:
  - IDLE: in_ready=0. On start=1, latch max_n_min and len.
    - len != 0: go to ACCUM. Clear count, clear acc_valid, set acc=0.
    - len == 0: go to FINISH with acc_valid=0.
  - ACCUM: in_ready=1. An element is accepted when in_valid & in_ready. For each accepted element with index = count:
    - NaN element: skipped; the accumulator is unchanged.
    - acc_valid=0: acc <= element, idx <= count, acc_valid <= 1.
    - Otherwise: replace acc and idx only if the element is strictly better (bigger for max, smaller for min). On a tie, including bit-identical values, the earlier index is kept.
    - count increments per accepted element. On accepting element count == len-1, go to FINISH.
    - Cycles with in_valid=0 are stalls and do not change state.
  - FINISH: for exactly one cycle, done=1 and in_ready=0.
    - acc_valid=1: res=acc, res_idx=idx, all_nan=0.
    - Otherwise: res=canonical NaN, res_idx=0, all_nan=1.
    - Next state is IDLE.
- res, res_idx and all_nan are registered. They are updated when entering FINISH and hold their values until the next FINISH or reset.
- Latency: done rises on the cycle after the handshake of the last element. For len=0, done rises 1 cycle after start. Minimum total for len=N with no stalls is N+1 cycles from start to done, with elements accepted on cycles 1..N after the start cycle.
- start is ignored while busy. start asserted in the FINISH cycle is ignored; it is accepted only on the following IDLE cycle.
- len=1: a single element becomes the result, or NaN with all_nan=1 if that element is NaN.
- The count does not wrap: the maximum len is 2^LEN_W-1, and the index fits in LEN_W bits.

Test Plan:
- max, len=4, data {0x3F800000, 0x40400000, 0xC0000000, 0x40000000}, no stalls -> done 5 cycles after start, res=0x40400000, res_idx=1, all_nan=0.
- min, len=3, data {0x80000000(-0), 0x00000000(+0), 0x80000000}, random in_valid gaps -> res=0x80000000, res_idx=0 (tie keeps earliest); in_ready=1 throughout ACCUM; done exactly once.
- max, len=3, data {0x7FC00001, 0xFF800000(-inf), 0x7FA00000}; then len=2 with both elements NaN -> first run: res=0xFF800000, res_idx=1. Second run: res=0x7FC00000, all_nan=1, res_idx=0.
- start with len=0 -> done on the next cycle, res=0x7FC00000, all_nan=1, and in_ready never asserted. A start pulse during ACCUM is ignored and len/mode are unchanged.
- Reset mid-operation: assert rst=0 after 2 of 5 elements -> the next cycle has busy=0, in_ready=0, res=0, and no done pulse. A new len=1 run with {0x41200000} then gives res=0x41200000, res_idx=0.
- Back-to-back: start held high continuously across two len=2 runs -> the second run begins on the IDLE cycle after FINISH. Each run gives one done pulse, and the results match a reference-model comparison.
